if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/rv32_pipe_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 pipeline front end.
//   XLEN          : datapath width
//   NOP_INST_VAL  : instruction word shown when the fetch buffer is empty (addi x0,x0,0)
//   RESET_PC_DEF  : default first fetch address after reset
//   fetch_state_t : fetch sequencer states
package rv32_pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST_VAL = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO used for the fetch address queue and the
// instruction buffer.
//   clock, reset_n : clock and asynchronous active-low reset
//   flush          : empty the FIFO (wins over push and pop)
//   push/push_data : write an entry; ignored when full unless a pop frees a slot
//   pop            : drop the head entry; ignored when empty
//   head_data      : current head entry (stale when count is 0)
//   count          : occupancy, 0..2
module fetch_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      // a full FIFO can still accept a write when the head leaves this cycle
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, keeps up
// to two requests/entries in flight, and presents the head instruction to the
// IF/ID register. Redirects flush the buffer and discard stale responses.
//   clock, reset_n          : clock and asynchronous active-low reset
//   imem_req/addr/gnt       : request handshake to instruction memory
//   imem_rvalid/rdata       : in-order responses, at least one cycle after grant
//   stall                   : IF/ID holding, head is not consumed
//   redirect_valid/pc       : new fetch target (low two bits ignored)
//   if_pc/if_inst/if_valid  : head of the instruction buffer
//
// state | meaning
// BOOT  | first cycle after reset, no requests
// FETCH | issuing requests while capacity allows
// DRAIN | dropping responses to requests issued before a redirect
module if_fetch_unit
   import rv32_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_VAL
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [1:0]   outst_q, outst_d;
   logic [1:0]   discard_q, discard_d;

   logic [31:0]  aq_head;
   logic [1:0]   aq_count;
   logic [63:0]  ib_head;
   logic [1:0]   ib_count;

   logic         grant;
   logic         rsp;
   logic         rsp_keep;
   logic         ib_pop;

   // outstanding plus buffered entries never exceeds the buffer depth, so a
   // response always has somewhere to land
   assign imem_req = (state_q == FETCH) && !redirect_valid &&
                     (({1'b0, outst_q} + {1'b0, ib_count}) < 3'd2);
   assign grant    = imem_req && imem_gnt;
   assign rsp      = imem_rvalid && (outst_q != 2'd0);
   assign rsp_keep = rsp && (discard_q == 2'd0) && !redirect_valid && (aq_count != 2'd0);
   assign ib_pop   = (ib_count != 2'd0) && !stall && !redirect_valid;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      outst_d   = outst_q;
      discard_d = discard_q;

      case (state_q)
         BOOT:    state_d = FETCH;
         DRAIN:   if (discard_q == 2'd0) state_d = FETCH;
         default: state_d = state_q;
      endcase

      if (grant) begin
         pc_d = pc_q + 32'd4;
      end

      case ({grant, rsp})
         2'b10:   outst_d = outst_q + 2'd1;
         2'b01:   outst_d = outst_q - 2'd1;
         default: outst_d = outst_q;
      endcase

      if (rsp && (discard_q != 2'd0)) begin
         discard_d = discard_q - 2'd1;
      end

      // no grant can coincide with a redirect, so outst_d is exactly what is
      // still in flight after this cycle's response; all of it is now stale
      if (redirect_valid) begin
         pc_d      = {redirect_pc[31:2], 2'b00};
         discard_d = outst_d;
         state_d   = (outst_d != 2'd0) ? DRAIN : FETCH;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         outst_q   <= 2'd0;
         discard_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   // addresses of non-stale requests, matched in order against responses
   fetch_fifo #(.WIDTH(32)) u_addr_q (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (redirect_valid),
      .push      (grant),
      .push_data (pc_q),
      .pop       (rsp_keep),
      .head_data (aq_head),
      .count     (aq_count)
   );

   fetch_fifo #(.WIDTH(64)) u_inst_buf (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data ({aq_head, imem_rdata}),
      .pop       (ib_pop),
      .head_data (ib_head),
      .count     (ib_count)
   );

   assign imem_addr = pc_q;
   assign if_valid  = (ib_count != 2'd0);
   assign if_pc     = if_valid ? ib_head[63:32] : 32'd0;
   assign if_inst   = if_valid ? ib_head[31:0]  : NOP_INST;

endmodule
